// File: rtl/iter_div_unit_if.sv
// iter_div_unit_if: request/result handshake bundle for the divider.
// master = EX-stage requester, slave = divider unit.
interface iter_div_unit_if #(
    parameter int XLEN = 64
);
    logic            start_valid;
    logic            start_ready;
    logic            op_signed;
    logic            op_32;
    logic            op_rem;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            cancel;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start_valid, op_signed, op_32, op_rem,
        output dividend, divisor, cancel, res_ready,
        input  start_ready, res_valid, result, busy
    );

    modport slave (
        input  start_valid, op_signed, op_32, op_rem,
        input  dividend, divisor, cancel, res_ready,
        output start_ready, res_valid, result, busy
    );
endinterface

// File: rtl/iter_div_unit.sv
// iter_div_unit: iterative restoring divider, BPC quotient bits per cycle.
// Covers div/divu/rem/remu and W forms, with cancel and fast paths.
module iter_div_unit #(
    parameter int XLEN = 64,
    parameter int BPC  = 1
) (
    input logic            clk,
    input logic            rst,
    iter_div_unit_if.slave bus
);
    localparam int STEPS = XLEN / BPC;
    localparam int CW    = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] q;
    logic [XLEN:0]   r;
    logic [XLEN-1:0] d;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            w_op;
    logic            rem_op;

    logic [XLEN-1:0] a_in, b_in;
    logic [XLEN-1:0] a_mag, b_mag, a_pre;
    logic [XLEN-1:0] min_val;
    logic [XLEN-1:0] spec_raw, spec_res;
    logic            a_neg, b_neg;
    logic            div0, ovf;

    logic [XLEN-1:0] quo_next;
    logic [XLEN:0]   rem_next;
    logic [XLEN:0]   diff;

    logic [XLEN-1:0] q_fix, r_fix;
    logic [XLEN-1:0] fix_raw, fix_res;

    function automatic logic [XLEN-1:0] ext32(
        input logic [XLEN-1:0] v,
        input logic            s
    );
        logic [XLEN-1:0] o;
        o = v;
        for (int i = 32; i < XLEN; i++) o[i] = s & v[31];
        return o;
    endfunction

    assign bus.start_ready = (state == IDLE) & ~rst;

    // Width-adjust the request, take magnitudes, detect fast paths
    always_comb begin
        a_in = bus.dividend;
        b_in = bus.divisor;
        if (bus.op_32) begin
            a_in = ext32(bus.dividend, bus.op_signed);
            b_in = ext32(bus.divisor, bus.op_signed);
        end
        a_neg = bus.op_signed & a_in[XLEN-1];
        b_neg = bus.op_signed & b_in[XLEN-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;
        // W dividends are left-aligned so the loop always
        // consumes bits from the top of q
        a_pre = bus.op_32 ? (a_mag << (XLEN - 32)) : a_mag;
        min_val = '0;
        if (bus.op_32) begin
            min_val[31] = 1'b1;
            min_val = ext32(min_val, 1'b1);
        end else begin
            min_val[XLEN-1] = 1'b1;
        end
        div0 = (b_in == '0);
        ovf  = bus.op_signed & (a_in == min_val) & (&b_in);
        if (div0) spec_raw = bus.op_rem ? a_in : '1;
        else spec_raw = bus.op_rem ? '0 : a_in;
        spec_res = bus.op_32 ? ext32(spec_raw, 1'b1) : spec_raw;
    end

    // BPC restoring steps on the partial remainder per CALC cycle
    always_comb begin
        quo_next = q;
        rem_next = r;
        diff     = '0;
        for (int i = 0; i < BPC; i++) begin
            rem_next = {rem_next[XLEN-1:0], quo_next[XLEN-1]};
            quo_next = {quo_next[XLEN-2:0], 1'b0};
            diff     = rem_next - {1'b0, d};
            if (!diff[XLEN]) begin
                rem_next    = diff;
                quo_next[0] = 1'b1;
            end
        end
    end

    // Sign fix-up and W sign-extension of the final result
    always_comb begin
        q_fix   = q_neg ? -q : q;
        r_fix   = r_neg ? -r[XLEN-1:0] : r[XLEN-1:0];
        fix_raw = rem_op ? r_fix : q_fix;
        fix_res = w_op ? ext32(fix_raw, 1'b1) : fix_raw;
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q             <= '0;
            r             <= '0;
            d             <= '0;
            cnt           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            w_op          <= 1'b0;
            rem_op        <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.result    <= '0;
            bus.busy      <= 1'b0;
        end else if (bus.cancel) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        w_op     <= bus.op_32;
                        rem_op   <= bus.op_rem;
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        bus.busy <= 1'b1;
                        if (div0 || ovf) begin
                            state         <= DONE;
                            bus.result    <= spec_res;
                            bus.res_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                            q     <= a_pre;
                            r     <= '0;
                            d     <= b_mag;
                            cnt   <= bus.op_32
                                   ? CW'(32 / BPC - 1)
                                   : CW'(STEPS - 1);
                        end
                    end
                end
                CALC: begin
                    q <= quo_next;
                    r <= rem_next;
                    if (cnt == '0) state <= FIX;
                    else cnt <= cnt - 1'b1;
                end
                FIX: begin
                    state         <= DONE;
                    bus.result    <= fix_res;
                    bus.res_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
